// File: rtl/ir_blk_ctrl.sv
// Block-assembly controller ahead of the OFDM interleaver: collects one Ncbps-bit
// block from the serial coded-bit stream and presents it, tagged, until accepted.
module ir_blk_ctrl #(
   parameter int unsigned MAX_BLK = 1152,
   parameter int unsigned CNT_W   = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         rate_id,
   input  logic [2:0]         subchan_ct,
   input  logic               in_bit,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   output logic [MAX_BLK-1:0] out_blk,
   output logic               out_blk_valid,
   input  logic               out_blk_ready,
   output logic [CNT_W-1:0]   out_ncbps,
   output logic [1:0]         out_mod,
   output logic               cfg_err,
   output logic [15:0]        blk_cnt
);

   localparam int unsigned BLK_CNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [MAX_BLK-1:0]     r_buf;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       r_ncbps;
   logic [1:0]             r_mod;
   logic                   r_cfg_err;
   logic [BLK_CNT_W-1:0]   r_blk_cnt;

   logic                   w_accept;
   logic                   w_code_ok;
   logic                   w_last;
   logic                   w_handoff;

   // Ncbps = 192*Ncpc at 16 subchannels, halved per subchannel code step
   function automatic logic [CNT_W-1:0] f_ncbps(input logic [1:0] rate,
                                                 input logic [2:0] code);
      logic [CNT_W-1:0] v_full;
      case (rate)
         2'd0:    v_full = CNT_W'(192);
         2'd1:    v_full = CNT_W'(384);
         2'd2:    v_full = CNT_W'(768);
         default: v_full = CNT_W'(1152);
      endcase
      return v_full >> code;
   endfunction

   assign in_ready  = ~reset & ~flush & (r_state != S_HOLD);
   assign w_accept  = in_valid & in_ready;
   assign w_code_ok = (subchan_ct <= 3'd4);
   assign w_last    = (r_cnt == (r_ncbps - CNT_W'(1)));
   assign w_handoff = (r_state == S_HOLD) & out_blk_ready;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; flush never aborts a completed block
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_code_ok) w_state_nxt = S_FILL;
         end
         S_FILL: begin
            if (flush)                  w_state_nxt = S_IDLE;
            else if (w_accept && w_last) w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (out_blk_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Block buffer, bit counter, latched tags and handoff counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf     <= '0;
         r_cnt     <= '0;
         r_ncbps   <= '0;
         r_mod     <= '0;
         r_cfg_err <= 1'b0;
         r_blk_cnt <= '0;
      end else begin
         r_cfg_err <= (r_state == S_IDLE) & w_accept & ~w_code_ok;
         case (r_state)
            S_IDLE: begin
               if (flush) begin
                  r_cnt <= '0;
               end else if (w_accept && w_code_ok) begin
                  r_buf   <= MAX_BLK'(in_bit);
                  r_cnt   <= CNT_W'(1);
                  r_ncbps <= f_ncbps(rate_id, subchan_ct);
                  r_mod   <= rate_id;
               end
            end
            S_FILL: begin
               if (flush) begin
                  r_cnt <= '0;
               end else if (w_accept) begin
                  r_buf[r_cnt] <= in_bit;
                  r_cnt        <= r_cnt + CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (w_handoff) begin
                  r_blk_cnt <= r_blk_cnt + BLK_CNT_W'(1);
                  r_cnt     <= '0;
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign out_blk       = r_buf;
   assign out_blk_valid = (r_state == S_HOLD);
   assign out_ncbps     = r_ncbps;
   assign out_mod       = r_mod;
   assign cfg_err       = r_cfg_err;
   assign blk_cnt       = r_blk_cnt;

endmodule
